// File: rtl/debug_bus_arbiter.sv
// Round-robin arbiter sharing one PVALID/PREADY bus port between the CPU
// load/store unit (M0) and the debug bridge (M1), with a hung-slave watchdog.
module debug_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        M0_VALID,
    output logic        M0_READY,
    output logic        M0_ERR,
    input  logic [3:0]  M0_WSTB,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic [31:0] M0_RDATA,
    input  logic        M1_VALID,
    output logic        M1_READY,
    output logic        M1_ERR,
    input  logic [3:0]  M1_WSTB,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic [31:0] M1_RDATA,
    output logic        PVALID,
    input  logic        PREADY,
    output logic [3:0]  PWSTB,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    output logic        TO_FLAG,
    input  logic        TO_CLR,
    output logic        TO_SRC
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic             r_last_gnt;
    logic             r_bubble;
    logic             r_to_flag;
    logic             r_to_src;
    logic [CNT_W-1:0] r_cnt;

    logic w_gnt0;
    logic w_gnt1;
    logic w_gnt;
    logic w_valid;
    logic w_to_hit;
    logic w_done;

    assign w_gnt0 = (r_state == GNT0);
    assign w_gnt1 = (r_state == GNT1);
    assign w_gnt  = w_gnt0 | w_gnt1;

    assign w_valid = (w_gnt0 & M0_VALID) | (w_gnt1 & M1_VALID);
    assign w_done  = w_valid & PREADY;
    // A ready slave on the deadline cycle still completes normally.
    assign w_to_hit = (TIMEOUT != 0) & w_valid & ~PREADY
                    & (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                // The bubble cycle after a completion never arbitrates.
                if (!r_bubble) begin
                    if (M0_VALID && (!M1_VALID || r_last_gnt))
                        w_nxt = GNT0;
                    else if (M1_VALID)
                        w_nxt = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!w_valid || w_done || w_to_hit)
                    w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign PVALID = w_valid & ~w_to_hit;
    assign PADDR  = w_gnt1 ? M1_ADDR  : (w_gnt0 ? M0_ADDR  : 32'd0);
    assign PWDATA = w_gnt1 ? M1_WDATA : (w_gnt0 ? M0_WDATA : 32'd0);
    assign PWSTB  = w_gnt1 ? M1_WSTB  : (w_gnt0 ? M0_WSTB  : 4'd0);

    assign M0_READY = w_gnt0 & (w_done | w_to_hit);
    assign M0_ERR   = w_gnt0 & w_to_hit;
    assign M0_RDATA = (w_gnt0 & w_done) ? PRDATA : 32'd0;
    assign M1_READY = w_gnt1 & (w_done | w_to_hit);
    assign M1_ERR   = w_gnt1 & w_to_hit;
    assign M1_RDATA = (w_gnt1 & w_done) ? PRDATA : 32'd0;

    assign TO_FLAG = r_to_flag;
    assign TO_SRC  = r_to_src;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_bubble   <= 1'b0;
            r_cnt      <= '0;
            r_to_flag  <= 1'b0;
            r_to_src   <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_bubble <= w_done | w_to_hit;
            if (r_state == IDLE && w_nxt != IDLE)
                r_last_gnt <= (w_nxt == GNT1);
            if (w_gnt && w_nxt != IDLE)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_to_hit) begin
                r_to_flag <= 1'b1;
                r_to_src  <= w_gnt1;
            end else if (TO_CLR) begin
                r_to_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter: TIMEOUT=4 main instance plus a
// TIMEOUT=0 instance for the disabled-watchdog case.
module tb_debug_bus_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        M0_VALID, M1_VALID;
    logic [3:0]  M0_WSTB, M1_WSTB;
    logic [31:0] M0_ADDR, M1_ADDR, M0_WDATA, M1_WDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        TO_CLR;

    logic        M0_READY, M0_ERR, M1_READY, M1_ERR;
    logic [31:0] M0_RDATA, M1_RDATA;
    logic        PVALID;
    logic [3:0]  PWSTB;
    logic [31:0] PADDR, PWDATA;
    logic        TO_FLAG, TO_SRC;

    logic        z_m0_valid, z_pready;
    logic        z_m0_ready, z_m0_err, z_m1_ready, z_m1_err;
    logic [31:0] z_m0_rdata, z_m1_rdata;
    logic        z_pvalid;
    logic [3:0]  z_pwstb;
    logic [31:0] z_paddr, z_pwdata;
    logic        z_to_flag, z_to_src;

    int n_cmp = 0;
    int n_err = 0;
    int bad;

    debug_bus_arbiter #(.TIMEOUT(4), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .M0_VALID(M0_VALID), .M0_READY(M0_READY), .M0_ERR(M0_ERR),
        .M0_WSTB(M0_WSTB), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_RDATA(M0_RDATA),
        .M1_VALID(M1_VALID), .M1_READY(M1_READY), .M1_ERR(M1_ERR),
        .M1_WSTB(M1_WSTB), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_RDATA(M1_RDATA),
        .PVALID(PVALID), .PREADY(PREADY), .PWSTB(PWSTB), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA),
        .TO_FLAG(TO_FLAG), .TO_CLR(TO_CLR), .TO_SRC(TO_SRC)
    );

    debug_bus_arbiter #(.TIMEOUT(0), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .M0_VALID(z_m0_valid), .M0_READY(z_m0_ready), .M0_ERR(z_m0_err),
        .M0_WSTB(M0_WSTB), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_RDATA(z_m0_rdata),
        .M1_VALID(1'b0), .M1_READY(z_m1_ready), .M1_ERR(z_m1_err),
        .M1_WSTB(M1_WSTB), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_RDATA(z_m1_rdata),
        .PVALID(z_pvalid), .PREADY(z_pready), .PWSTB(z_pwstb),
        .PADDR(z_paddr), .PWDATA(z_pwdata), .PRDATA(PRDATA),
        .TO_FLAG(z_to_flag), .TO_CLR(TO_CLR), .TO_SRC(z_to_src)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        RST_N = 0; M0_VALID = 0; M1_VALID = 0;
        M0_WSTB = 0; M1_WSTB = 0; M0_ADDR = 0; M1_ADDR = 0;
        M0_WDATA = 0; M1_WDATA = 0; PREADY = 0; PRDATA = 0; TO_CLR = 0;
        z_m0_valid = 0; z_pready = 0;

        // Reset state
        tick(); #1;
        chk("rst_pvalid", {31'd0, PVALID}, 32'd0);
        chk("rst_to_flag", {31'd0, TO_FLAG}, 32'd0);
        chk("rst_m0_ready", {31'd0, M0_READY}, 32'd0);
        RST_N = 1;

        // Single CPU read, two wait cycles
        tick();
        M0_VALID = 1; M0_ADDR = 32'h100; M0_WSTB = 0; #1;
        chk("t1_idle_pvalid", {31'd0, PVALID}, 32'd0);
        tick(); #1;
        chk("t1_c2_pvalid", {31'd0, PVALID}, 32'd1);
        chk("t1_c2_paddr", PADDR, 32'h100);
        chk("t1_c2_ready", {31'd0, M0_READY}, 32'd0);
        tick(); #1;
        chk("t1_c3_pvalid", {31'd0, PVALID}, 32'd1);
        tick();
        PREADY = 1; PRDATA = 32'h12345678; #1;
        chk("t1_c4_pvalid", {31'd0, PVALID}, 32'd1);
        chk("t1_ready", {31'd0, M0_READY}, 32'd1);
        chk("t1_rdata", M0_RDATA, 32'h12345678);
        chk("t1_err", {31'd0, M0_ERR}, 32'd0);
        chk("t1_m1_ready", {31'd0, M1_READY}, 32'd0);
        tick();
        M0_VALID = 0; PREADY = 0; #1;
        chk("t1_after_pvalid", {31'd0, PVALID}, 32'd0);
        chk("t1_after_ready", {31'd0, M0_READY}, 32'd0);

        // Continuous contention, zero-wait slave; last grant was M0
        tick();
        M0_VALID = 1; M0_ADDR = 32'h1000;
        M1_VALID = 1; M1_ADDR = 32'h8000_0000;
        PREADY = 1; PRDATA = 32'hCAFE0000; #1;
        chk("t2_idle_pvalid", {31'd0, PVALID}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t2_gnt_pvalid", {31'd0, PVALID}, 32'd1);
            chk("t2_gnt_paddr", PADDR,
                (k % 2 == 0) ? 32'h8000_0000 : 32'h1000);
            chk("t2_m1_ready", {31'd0, M1_READY}, (k % 2 == 0) ? 1 : 0);
            chk("t2_m0_ready", {31'd0, M0_READY}, (k % 2 == 0) ? 0 : 1);
            tick();
            if (k == 3) begin
                M0_VALID = 0; M1_VALID = 0; PREADY = 0;
            end
            #1;
            chk("t2_bubble_pvalid", {31'd0, PVALID}, 32'd0);
            tick(); #1;
            chk("t2_arb_pvalid", {31'd0, PVALID}, 32'd0);
        end

        // M1 write into a hung slave, TIMEOUT=4
        tick();
        M1_VALID = 1; M1_ADDR = 32'h2000; M1_WSTB = 4'b0011;
        M1_WDATA = 32'hA5A5_5A5A; #1;
        chk("t3_idle_pvalid", {31'd0, PVALID}, 32'd0);
        for (int g = 1; g <= 4; g++) begin
            tick(); #1;
            chk("t3_wait_pvalid", {31'd0, PVALID}, 32'd1);
            chk("t3_wait_ready", {31'd0, M1_READY}, 32'd0);
            if (g == 1) begin
                chk("t3_pwstb", {28'd0, PWSTB}, 32'h3);
                chk("t3_pwdata", PWDATA, 32'hA5A5_5A5A);
            end
        end
        tick();
        TO_CLR = 1; #1;
        chk("t3_abort_pvalid", {31'd0, PVALID}, 32'd0);
        chk("t3_abort_ready", {31'd0, M1_READY}, 32'd1);
        chk("t3_abort_err", {31'd0, M1_ERR}, 32'd1);
        chk("t3_abort_rdata", M1_RDATA, 32'd0);
        chk("t3_abort_m0_ready", {31'd0, M0_READY}, 32'd0);
        chk("t3_flag_pre", {31'd0, TO_FLAG}, 32'd0);
        tick();
        M1_VALID = 0; #1;
        chk("t3_flag_set_wins", {31'd0, TO_FLAG}, 32'd1);
        chk("t3_to_src", {31'd0, TO_SRC}, 32'd1);
        tick();
        TO_CLR = 0; #1;
        chk("t3_flag_cleared", {31'd0, TO_FLAG}, 32'd0);
        chk("t3_src_kept", {31'd0, TO_SRC}, 32'd1);

        // PREADY arrives exactly on the deadline cycle
        tick();
        M0_VALID = 1; M0_ADDR = 32'h300; #1;
        chk("t4_idle_pvalid", {31'd0, PVALID}, 32'd0);
        for (int g = 1; g <= 4; g++) begin
            tick(); #1;
            chk("t4_wait_ready", {31'd0, M0_READY}, 32'd0);
        end
        tick();
        PREADY = 1; PRDATA = 32'h0BAD_F00D; #1;
        chk("t4_pvalid", {31'd0, PVALID}, 32'd1);
        chk("t4_ready", {31'd0, M0_READY}, 32'd1);
        chk("t4_err", {31'd0, M0_ERR}, 32'd0);
        chk("t4_rdata", M0_RDATA, 32'h0BAD_F00D);
        tick();
        M0_VALID = 0; PREADY = 0; #1;
        chk("t4_flag", {31'd0, TO_FLAG}, 32'd0);

        // Disabled watchdog, slave stalled 1000 cycles
        tick();
        z_m0_valid = 1; M0_ADDR = 32'h400;
        bad = 0;
        repeat (1000) begin
            tick(); #1;
            if (!(z_pvalid === 1'b1 && z_m0_ready === 1'b0)) bad++;
        end
        chk("t5_stall_cycles_bad", bad, 32'd0);
        tick();
        z_pready = 1; #1;
        chk("t5_ready", {31'd0, z_m0_ready}, 32'd1);
        chk("t5_err", {31'd0, z_m0_err}, 32'd0);
        chk("t5_rdata", z_m0_rdata, 32'h0BAD_F00D);
        chk("t5_flag", {31'd0, z_to_flag}, 32'd0);
        tick();
        z_m0_valid = 0; z_pready = 0;

        // Reset while GNT1 is stalled
        tick();
        M1_VALID = 1; M1_ADDR = 32'h9000; #1;
        tick(); #1;
        chk("t6_gnt1_pvalid", {31'd0, PVALID}, 32'd1);
        chk("t6_gnt1_paddr", PADDR, 32'h9000);
        tick();
        #2 RST_N = 0; #1;
        chk("t6_rst_pvalid", {31'd0, PVALID}, 32'd0);
        chk("t6_rst_paddr", PADDR, 32'd0);
        chk("t6_rst_ready", {31'd0, M1_READY}, 32'd0);
        chk("t6_rst_err", {31'd0, M1_ERR}, 32'd0);
        chk("t6_rst_to_src", {31'd0, TO_SRC}, 32'd0);
        tick(); #1;
        chk("t6_rst_hold_ready", {31'd0, M1_READY}, 32'd0);
        M0_VALID = 1; M0_ADDR = 32'h1000; RST_N = 1;
        tick(); #1;
        chk("t6_first_pvalid", {31'd0, PVALID}, 32'd1);
        chk("t6_first_paddr", PADDR, 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
